// File: rtl/adpll_lock_detect.sv
// Lock detector for the ADPLL loop-filter output. Each {sign,dout} sample is checked against an
// amplitude window and a slew limit. A hysteretic FSM then asserts and drops 'locked'.
module adpll_lock_detect #(
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned LOCK_CYCLES   = 64,
   parameter int unsigned UNLOCK_CYCLES = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             sample,
   input  logic             sign,
   input  logic [4:0]       dout,
   input  logic [4:0]       win,
   input  logic [4:0]       slew,
   output logic             locked,
   output logic [1:0]       lock_state,
   output logic             lock_lost,
   output logic [CNT_W-1:0] lock_cnt
);

   localparam int unsigned DW  = 5;
   localparam int unsigned VW  = DW + 1;
   localparam int unsigned DLW = VW + 1;
   localparam int unsigned CW1 = CNT_W + 1;

   localparam logic [CW1-1:0] LOCK_TC   = CW1'(LOCK_CYCLES);
   localparam logic [CW1-1:0] UNLOCK_TC = CW1'(UNLOCK_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_SEARCH  = 2'b01,
      ST_ACQUIRE = 2'b10,
      ST_LOCKED  = 2'b11
   } state_e;

   state_e           state_q,      state_d;
   logic             locked_q,     locked_d;
   logic             lock_lost_q,  lock_lost_d;
   logic [CNT_W-1:0] lock_cnt_q,   lock_cnt_d;
   logic [CNT_W-1:0] bad_cnt_q,    bad_cnt_d;
   logic [VW-1:0]    prev_value_q, prev_value_d;
   logic             prev_valid_q, prev_valid_d;

   logic [VW-1:0]    value_c;
   logic [DLW-1:0]   delta_c;
   logic [DLW-1:0]   delta_mag_c;
   logic             win_ok_c;
   logic             slew_ok_c;
   logic             good_c;
   logic [CW1-1:0]   lock_inc_c;
   logic [CW1-1:0]   bad_inc_c;

   // Sign-magnitude to two's complement; -0 naturally folds to +0.
   always_comb begin
      value_c     = sign ? (VW'(0) - {1'b0, dout}) : {1'b0, dout};
      delta_c     = {value_c[VW-1], value_c} - {prev_value_q[VW-1], prev_value_q};
      delta_mag_c = delta_c[DLW-1] ? (DLW'(0) - delta_c) : delta_c;
      win_ok_c    = (dout <= win);
      slew_ok_c   = (delta_mag_c <= DLW'(slew));
      good_c      = win_ok_c && (!prev_valid_q || slew_ok_c);
      lock_inc_c  = CW1'(lock_cnt_q) + CW1'(1);
      bad_inc_c   = CW1'(bad_cnt_q) + CW1'(1);
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      locked_d     = locked_q;
      lock_lost_d  = 1'b0;
      lock_cnt_d   = lock_cnt_q;
      bad_cnt_d    = bad_cnt_q;
      prev_value_d = prev_value_q;
      prev_valid_d = prev_valid_q;

      if (!en) begin
         state_d      = ST_IDLE;
         locked_d     = 1'b0;
         lock_cnt_d   = '0;
         bad_cnt_d    = '0;
         prev_valid_d = 1'b0;
      end else begin
         // A sample in the IDLE exit cycle is dropped entirely, history included.
         if (sample && (state_q != ST_IDLE)) begin
            prev_value_d = value_c;
            prev_valid_d = 1'b1;
         end

         unique case (state_q)
            ST_IDLE: begin
               state_d      = ST_SEARCH;
               prev_valid_d = 1'b0;
            end

            ST_SEARCH: begin
               if (sample && good_c) begin
                  state_d    = ST_ACQUIRE;
                  lock_cnt_d = CNT_W'(1);
               end
            end

            ST_ACQUIRE: begin
               if (sample) begin
                  if (!good_c) begin
                     state_d    = ST_SEARCH;
                     lock_cnt_d = '0;
                  end else if (lock_inc_c == LOCK_TC) begin
                     state_d    = ST_LOCKED;
                     locked_d   = 1'b1;
                     lock_cnt_d = '0;
                     bad_cnt_d  = '0;
                  end else begin
                     lock_cnt_d = CNT_W'(lock_inc_c);
                  end
               end
            end

            ST_LOCKED: begin
               if (sample) begin
                  if (good_c) begin
                     bad_cnt_d = '0;
                  end else if (bad_inc_c == UNLOCK_TC) begin
                     state_d     = ST_SEARCH;
                     locked_d    = 1'b0;
                     lock_lost_d = 1'b1;
                     bad_cnt_d   = '0;
                  end else begin
                     bad_cnt_d = CNT_W'(bad_inc_c);
                  end
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= ST_IDLE;
         locked_q     <= 1'b0;
         lock_lost_q  <= 1'b0;
         lock_cnt_q   <= '0;
         bad_cnt_q    <= '0;
         prev_value_q <= '0;
         prev_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         locked_q     <= locked_d;
         lock_lost_q  <= lock_lost_d;
         lock_cnt_q   <= lock_cnt_d;
         bad_cnt_q    <= bad_cnt_d;
         prev_value_q <= prev_value_d;
         prev_valid_q <= prev_valid_d;
      end
   end

   assign locked     = locked_q;
   assign lock_state = state_q;
   assign lock_lost  = lock_lost_q;
   assign lock_cnt   = lock_cnt_q;

endmodule
